// File: rtl/aes_pkg.sv
// Shared AES helpers: reduction polynomial, sequencer state encoding,
// column/byte slicing and the GF(2^8) xtime primitive.
package aes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1B;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    // Column c lives in bits [127-32c -: 32]; column 0 is the most significant word.
    function automatic logic [31:0] get_col(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] col;
        case (c)
            2'd0:    col = s[127:96];
            2'd1:    col = s[95:64];
            2'd2:    col = s[63:32];
            default: col = s[31:0];
        endcase
        return col;
    endfunction

    function automatic logic [127:0] put_col(input logic [127:0] s, input logic [1:0] c,
                                             input logic [31:0] v);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[127:96] = v;
            2'd1:    r[95:64]  = v;
            2'd2:    r[63:32]  = v;
            default: r[31:0]   = v;
        endcase
        return r;
    endfunction

    // Row 0 is the most significant byte of a column.
    function automatic logic [7:0] col_byte(input logic [31:0] col, input logic [1:0] r);
        logic [7:0] b;
        case (r)
            2'd0:    b = col[31:24];
            2'd1:    b = col[23:16];
            2'd2:    b = col[15:8];
            default: b = col[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mixcol_col_engine.sv
// One-column MixColumns / InvMixColumns engine, purely combinational.
module mixcol_col_engine
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    input  logic        dec_i,
    output logic [31:0] col_o
);

    logic [7:0] a   [4];
    logic [7:0] x2  [4];
    logic [7:0] x4  [4];
    logic [7:0] x8  [4];
    logic [7:0] m_e [4];
    logic [7:0] m_b [4];
    logic [7:0] m_d [4];
    logic [7:0] m_9 [4];

    // With x4/x8 held at 0 the inverse coefficients 0E/0B/0D/09 collapse to
    // 02/03/01/01, so one XOR network serves both directions.
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign a[gi]   = col_byte(col_i, 2'(gi));
        assign x2[gi]  = xtime(a[gi]);
        assign x4[gi]  = dec_i ? xtime(x2[gi]) : 8'h00;
        assign x8[gi]  = dec_i ? xtime(x4[gi]) : 8'h00;
        assign m_e[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
        assign m_b[gi] = x8[gi] ^ x2[gi] ^ a[gi];
        assign m_d[gi] = x8[gi] ^ x4[gi] ^ a[gi];
        assign m_9[gi] = x8[gi] ^ a[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign col_o[31-8*gi -: 8] = m_e[gi] ^ m_b[(gi+1)%4] ^ m_d[(gi+2)%4] ^ m_9[(gi+3)%4];
    end

endmodule

// File: rtl/mixcol_seq.sv
// Column-serial MixColumns/InvMixColumns sequencer with valid/ready on both sides
// and a bypass path for the final AES round.
module mixcol_seq
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_dec,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int         NSTEP     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] STEP_LAST = 2'(NSTEP - 1);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    logic [1:0]   fsm_q, fsm_d;
    logic [1:0]   step_q, step_d;
    logic         dec_q, dec_d;
    logic [127:0] state_q, state_d;
    logic [127:0] result_q, result_d;

    logic [1:0]  col_idx [COLS_PER_CYCLE];
    logic [31:0] eng_in  [COLS_PER_CYCLE];
    logic [31:0] eng_out [COLS_PER_CYCLE];

    for (genvar gi = 0; gi < COLS_PER_CYCLE; gi++) begin : g_eng
        assign col_idx[gi] = 2'(32'(step_q) * 32'(COLS_PER_CYCLE) + 32'(gi));
        assign eng_in[gi]  = get_col(state_q, col_idx[gi]);

        mixcol_col_engine u_engine (
            .col_i (eng_in[gi]),
            .dec_i (dec_q),
            .col_o (eng_out[gi])
        );
    end

    always_comb begin
        fsm_d    = fsm_q;
        step_d   = step_q;
        dec_d    = dec_q;
        state_d  = state_q;
        result_d = result_q;
        case (fsm_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = in_state;
                    dec_d   = in_dec;
                    step_d  = 2'd0;
                    if (in_bypass) begin
                        result_d = in_state;
                        fsm_d    = ST_DONE;
                    end else begin
                        fsm_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    result_d = put_col(result_d, col_idx[k], eng_out[k]);
                end
                if (step_q == STEP_LAST) begin
                    fsm_d  = ST_DONE;
                    step_d = 2'd0;
                end else begin
                    step_d = step_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q    <= ST_IDLE;
            step_q   <= 2'd0;
            dec_q    <= 1'b0;
            state_q  <= 128'h0;
            result_q <= 128'h0;
        end else begin
            fsm_q    <= fsm_d;
            step_q   <= step_d;
            dec_q    <= dec_d;
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign in_ready  = (fsm_q == ST_IDLE);
    assign out_valid = (fsm_q == ST_DONE);
    assign busy      = (fsm_q == ST_RUN) || (fsm_q == ST_DONE);
    assign out_state = result_q;

endmodule

// File: tb/tb_mixcol_seq.sv
// Scoreboard bench for mixcol_seq at COLS_PER_CYCLE = 1, 2 and 4.
module tb_mixcol_seq;

    localparam logic [127:0] FIPS_IN  = 128'hdb135345_f20a225c_01010101_2d26314c;
    localparam logic [127:0] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
    localparam logic [127:0] BYP_ST   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] C6_ST    = 128'hc6c6c6c6_c6c6c6c6_c6c6c6c6_c6c6c6c6;
    localparam logic [127:0] D4_IN    = 128'hd4d4d4d5_01010101_c6c6c6c6_01010101;
    localparam logic [127:0] D4_OUT   = 128'hd5d5d7d6_01010101_c6c6c6c6_01010101;

    typedef struct {
        int           id;
        logic [127:0] exp;
        int           acc;
        int           lat;
    } sb_t;

    sb_t sb_q[$];

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    logic         iv   [3];
    logic [127:0] ist  [3];
    logic         idec [3];
    logic         ibyp [3];
    logic         ordy [3];
    logic         ir   [3];
    logic         ov   [3];
    logic         bsy  [3];
    logic [127:0] ost  [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mixcol_seq #(.COLS_PER_CYCLE(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[gi]),
            .in_ready  (ir[gi]),
            .in_state  (ist[gi]),
            .in_dec    (idec[gi]),
            .in_bypass (ibyp[gi]),
            .out_valid (ov[gi]),
            .out_ready (ordy[gi]),
            .out_state (ost[gi]),
            .busy      (bsy[gi])
        );

        initial begin : monitor
            bit  seen;
            int  vcyc;
            sb_t e;
            seen = 1'b0;
            vcyc = 0;
            forever begin
                @(negedge clk);
                if (!rst) begin
                    checks++;
                    if (ir[gi] !== !bsy[gi]) begin
                        errors++;
                        $display("FAIL ready_vs_busy dut%0d: in_ready=%b busy=%b", gi, ir[gi], bsy[gi]);
                    end
                end
                if (ov[gi] !== 1'b1) seen = 1'b0;
                else if (!seen) begin
                    seen = 1'b1;
                    vcyc = cyc;
                end
                if (ov[gi] === 1'b1 && ordy[gi] === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output dut%0d: got %h with empty scoreboard", gi, ost[gi]);
                    end else begin
                        e = sb_q.pop_front();
                        checks++;
                        if (e.id != gi || ost[gi] !== e.exp) begin
                            errors++;
                            $display("FAIL out_state dut%0d: got %h expected %h (from dut%0d)",
                                     gi, ost[gi], e.exp, e.id);
                        end
                        checks++;
                        if (vcyc - e.acc + 1 != e.lat) begin
                            errors++;
                            $display("FAIL latency dut%0d: got %0d expected %0d", gi, vcyc - e.acc + 1, e.lat);
                        end
                    end
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int id, input logic [127:0] st, input logic dec, input logic byp,
                        input logic [127:0] exp, input int lat, input bit expect_out);
        int budget;
        budget = 0;
        ist[id]  = st;
        idec[id] = dec;
        ibyp[id] = byp;
        iv[id]   = 1'b1;
        while (ir[id] !== 1'b1 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 50) begin
            errors++;
            $display("FAIL accept_timeout dut%0d: in_ready never rose", id);
            iv[id] = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        iv[id] = 1'b0;
        if (expect_out) sb_q.push_back('{id, exp, cyc, lat});
        $display("dut%0d accept state=%h dec=%b bypass=%b at cycle %0d", id, st, dec, byp, cyc);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((sb_q.size() != 0 || bsy[0] || bsy[1] || bsy[2]) && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 200) begin
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        int a1, a2, budget;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; ist[i] = 128'h0; idec[i] = 1'b0; ibyp[i] = 1'b0; ordy[i] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 128'(ir[0]), 128'd1);
        chk("reset_out_valid", 128'(ov[0]), 128'd0);
        chk("reset_busy", 128'(bsy[0]), 128'd0);
        chk("reset_out_state", ost[0], 128'h0);

        // Encrypt and round trip at every engine count.
        send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, 1'b1);
        wait_idle();
        send(0, FIPS_OUT, 1'b1, 1'b0, FIPS_IN, 5, 1'b1);
        wait_idle();
        send(1, FIPS_OUT, 1'b1, 1'b0, FIPS_IN, 3, 1'b1);
        a1 = cyc;
        send(1, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 3, 1'b1);
        a2 = cyc;
        chk("throughput_c2", 128'(a2 - a1), 128'd4);
        wait_idle();
        send(2, FIPS_OUT, 1'b1, 1'b0, FIPS_IN, 2, 1'b1);
        a1 = cyc;
        send(2, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 2, 1'b1);
        a2 = cyc;
        chk("throughput_c4", 128'(a2 - a1), 128'd3);
        wait_idle();

        send(0, BYP_ST, 1'b0, 1'b1, BYP_ST, 1, 1'b1);
        wait_idle();
        send(0, BYP_ST, 1'b1, 1'b1, BYP_ST, 1, 1'b1);
        wait_idle();
        send(0, C6_ST, 1'b0, 1'b0, C6_ST, 5, 1'b1);
        wait_idle();

        // Backpressure: result held, new request ignored until the out handshake.
        ordy[0] = 1'b0;
        send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, 1'b1);
        budget = 0;
        while (ov[0] !== 1'b1 && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("bp_out_valid", 128'(ov[0]), 128'd1);
        ist[0] = FIPS_OUT; idec[0] = 1'b1; ibyp[0] = 1'b0; iv[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_state_stable", ost[0], FIPS_OUT);
            chk("bp_in_ready_low", 128'(ir[0]), 128'd0);
        end
        @(posedge clk);
        #1;
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_ready_after_hs", 128'(ir[0]), 128'd1);
        chk("bp_busy_after_hs", 128'(bsy[0]), 128'd0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        chk("bp_accept_next", 128'(bsy[0]), 128'd1);
        sb_q.push_back('{0, FIPS_IN, cyc, 5});
        $display("dut0 accept state=%h dec=1 bypass=0 at cycle %0d", FIPS_OUT, cyc);
        wait_idle();

        // Reset during RUN step 2, then during DONE.
        send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_run_busy", 128'(bsy[0]), 128'd0);
        chk("rst_run_out_valid", 128'(ov[0]), 128'd0);
        chk("rst_run_cleared", ost[0], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_run_in_ready", 128'(ir[0]), 128'd1);
        ordy[0] = 1'b0;
        send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, 1'b0);
        repeat (6) @(negedge clk);
        chk("rst_done_pre_valid", 128'(ov[0]), 128'd1);
        rst = 1'b1;
        #1;
        chk("rst_done_out_valid", 128'(ov[0]), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        ordy[0] = 1'b1;
        #1;
        send(0, D4_IN, 1'b0, 1'b0, D4_OUT, 5, 1'b1);
        wait_idle();

        // Input pins churn while the block is running.
        send(0, FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ist[0]  = {$urandom, $urandom, $urandom, $urandom};
            idec[0] = ~idec[0];
            ibyp[0] = ~ibyp[0];
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
